multiphase_signal_controller: RTL
=================================

# multiphase_signal_controller

Parametrised traffic-signal controller for intersections of 2 to 4 approach phases. It has per-phase vehicle sensors and latched walk requests, and grants a one-time green extension per phase visit. A clock divider, a programmable timing register file and the phase-sequencing FSM are built in. It sits below the top-level intersection wrapper, which supplies already-synchronised inputs and drives the lamp pins directly from this block's registered outputs.

## Interface
- N_PHASES, 3: number of approach phases, legal 2..4; phase 0 is the main road.
- TIME_W, 4: width of each timing value, counted in ticks.
- DIV, 4: number of clk cycles per timing tick, ≥2.
- DEF_GREEN / DEF_EXT / DEF_YEL / DEF_WALK, 4 / 2 / 2 / 3: reset values of the timing registers.
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- sensor  in  N_PHASES  vehicle present per phase; level, already synchronised.
- walk_req  in  N_PHASES  pedestrian request per phase; level or pulse, already synchronised.
- reprogram  in  1  one-cycle strobe that writes `time_val` into the register chosen by `time_sel`.
- time_sel  in  2  register select: 0 = green, 1 = extension, 2 = yellow, 3 = walk.
- time_val  in  TIME_W  value to write.
- red, yellow, green  out  N_PHASES each  lamp drives, one-hot per phase, registered.
- walk  out  N_PHASES  walk lamp per phase, registered.
- phase  out  2  index of the phase currently being served.

## Operation
- **FSM states:** GREEN, YELLOW, ALLRED, WALK. The current phase is held in `p`.
- **Outputs by state:**
  - GREEN: green[p]=1, red on all other phases.
  - YELLOW: yellow[p]=1, red on all other phases.
  - ALLRED and WALK: all red.
  - Exactly one of red/yellow/green is 1 per phase in every cycle.
- **Timing registers:**
  - Four TIME_W-bit registers, written on `reprogram` at `time_sel`.
  - A written value of 0 is stored as 1.
  - ALLRED has a fixed length of 1 tick.
- **Reprogram:** writes the register, then forces GREEN for phase 0 with `ext_used` cleared. The timer restarts next cycle using the new values. Walk latches are kept.
- **Next-phase search:** `nxt` is the first phase in order p+1, p+2, … (mod N_PHASES) whose sensor is 1. Phase 0 is always eligible, so `nxt` = 0 when no other phase is requesting.
- **GREEN expiry:**
  - If p≠0, sensor[p]=1 and `ext_used`=0: reload with the extension value, set `ext_used`, stay in GREEN.
  - Else if p=0 and nxt=0 and no walk is pending: rest in GREEN and reload with the green value.
  - Otherwise go to YELLOW.
- **YELLOW expiry:** go to ALLRED.
- **ALLRED expiry:**
  - If any walk latch is set: go to WALK.
  - Otherwise: set p = nxt, go to GREEN and clear `ext_used`.
- **Walk latches:**
  - `walk_pend[j]` is set by walk_req[j].
  - On entry to WALK, the pending set is copied into `served` and cleared in the same edge; walk = `served` for the whole WALK state.
  - A request arriving during WALK re-latches.
  - If a set and a clear hit the same edge, the set wins.
- **WALK expiry:** clear `served`, set p = nxt (evaluated at expiry), go to GREEN.

## Timing
- **Divider:** counts 0..DIV-1. It is restarted to 0 on every state entry, every reload and every reprogram, so every interval of V ticks lasts exactly V·DIV clk cycles.
- **Timer:** loaded with V on entry and decremented at each divider wrap. Expiry occurs at the wrap where the timer is 1. The new state and outputs are visible the following cycle.
- **Reset values:**
  - State GREEN, p=0, phase=0.
  - green=0…01, red=1…10, yellow=0, walk=0.
  - Timing registers at their DEF_* values; walk latches, `served` and `ext_used` all 0.
- **Reset mid-interval:** the reset values appear one cycle after reset is sampled high.
- **Input latency:** `sensor` is sampled only at expiry; `walk_req` is latched 1 cycle after it is asserted.

## Test plan
- **Idle rest:** reset, sensors and walk_req all 0 for 200 cycles -> green[0]=1 throughout; yellow never asserts; phase=0.
- **Extension:** sensor[1] held at 1, defaults, DIV=4 -> green[0] lasts 16 cycles, yellow[0] 8, all-red 4, green[1] 24 (16 + 8 extension), yellow[1] 8, then green[0]. No second extension is granted.
- **Phase skipping:** sensor=3'b100 -> sequence 0→2→0; phase 1 never turns green.
- **Walk service:** 1-cycle pulse on walk_req[2] during green[0], sensor=0 -> after yellow[0] and all-red, walk=3'b100 for 12 cycles with all lamps red; then green[0]; walk_pend is cleared.
- **Reprogram:** during yellow[1], write time_sel=2 with value 0 -> GREEN on phase 0 the next cycle; the next yellow lasts 4 cycles (the 0 is stored as 1).
- **Reset mid-walk:** assert reset during WALK -> next cycle green[0]=1, walk=0, and the walk latches are 0.

Source files
------------

// File: rtl/multiphase_signal_controller.sv
// Multiphase traffic-signal controller for 2..4 approach phases.
//
// Serves phases in round-robin order, skipping phases with no vehicle present.
// Phase 0 (main road) rests in green when nothing else is waiting. Each green
// visit of a side phase can be extended once while its sensor stays active.
// Pedestrian requests are latched and served in a dedicated all-red WALK
// interval that follows the all-red clearance.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   sensor     per-phase vehicle presence (synchronised level)
//   walk_req   per-phase pedestrian request (synchronised level or pulse)
//   reprogram  one-cycle strobe writing time_val into timing register time_sel
//   time_sel   0 = green, 1 = extension, 2 = yellow, 3 = walk
//   time_val   timing value in ticks (0 is stored as 1)
//   red/yellow/green  registered lamp drives, exactly one set per phase
//   walk       registered walk lamps
//   phase      index of the phase currently being served
module multiphase_signal_controller #(
  parameter int unsigned N_PHASES  = 3,
  parameter int unsigned TIME_W    = 4,
  parameter int unsigned DIV       = 4,
  parameter int unsigned DEF_GREEN = 4,
  parameter int unsigned DEF_EXT   = 2,
  parameter int unsigned DEF_YEL   = 2,
  parameter int unsigned DEF_WALK  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_PHASES-1:0] sensor,
  input  logic [N_PHASES-1:0] walk_req,
  input  logic                reprogram,
  input  logic [1:0]          time_sel,
  input  logic [TIME_W-1:0]   time_val,
  output logic [N_PHASES-1:0] red,
  output logic [N_PHASES-1:0] yellow,
  output logic [N_PHASES-1:0] green,
  output logic [N_PHASES-1:0] walk,
  output logic [1:0]          phase
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {StGreen, StYellow, StAllred, StWalk} state_e;

  // Timing register indices
  localparam int unsigned TGreen = 0;
  localparam int unsigned TExt   = 1;
  localparam int unsigned TYel   = 2;
  localparam int unsigned TWalk  = 3;

  state_e               st_q, st_d;
  logic [1:0]           p_q, p_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [TIME_W-1:0]    tmr_q, tmr_d;
  logic                 ext_used_q, ext_used_d;
  logic [N_PHASES-1:0]  walk_pend_q, walk_pend_d;
  logic [N_PHASES-1:0]  served_q, served_d;
  logic [TIME_W-1:0]    tim_q [4];
  logic [TIME_W-1:0]    tim_d [4];

  logic [N_PHASES-1:0]  red_q, red_d;
  logic [N_PHASES-1:0]  yellow_q, yellow_d;
  logic [N_PHASES-1:0]  green_q, green_d;
  logic [N_PHASES-1:0]  walk_q, walk_d;

  logic [1:0]           nxt;
  logic [3:0]           elig;
  logic [3:0]           sens4;
  logic [3:0]           sel4;
  logic                 wrap;
  logic                 expire;
  logic                 walk_any;
  logic [TIME_W-1:0]    wr_val;

  assign sens4    = 4'(sensor);
  // Phase 0 is always a legal destination, so the search never comes up empty.
  assign elig     = sens4 | 4'b0001;
  assign wrap     = (div_q == DivW'(DIV - 1));
  assign expire   = wrap && (tmr_q <= TIME_W'(1));
  assign walk_any = |walk_pend_q;
  assign wr_val   = (time_val == '0) ? TIME_W'(1) : time_val;

  // First eligible phase after p in cyclic order.
  always_comb begin
    int unsigned j;
    logic        found;
    nxt   = 2'd0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 1; k < N_PHASES; k++) begin
      j = {30'd0, p_q} + k;
      if (j >= N_PHASES) j = j - N_PHASES;
      if (!found && elig[j[1:0]]) begin
        nxt   = j[1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    st_d        = st_q;
    p_d         = p_q;
    div_d       = div_q;
    tmr_d       = tmr_q;
    ext_used_d  = ext_used_q;
    served_d    = served_q;
    tim_d       = tim_q;
    // New requests always land, even on the edge that consumes the latches.
    walk_pend_d = walk_pend_q | walk_req;

    if (reprogram) begin
      tim_d[time_sel] = wr_val;
      st_d            = StGreen;
      p_d             = 2'd0;
      ext_used_d      = 1'b0;
      served_d        = '0;
      div_d           = '0;
      tmr_d           = tim_d[TGreen];
    end else if (!wrap) begin
      div_d = div_q + DivW'(1);
    end else if (!expire) begin
      div_d = '0;
      tmr_d = tmr_q - TIME_W'(1);
    end else begin
      div_d = '0;
      unique case (st_q)
        StGreen: begin
          if (p_q != 2'd0 && sens4[p_q] && !ext_used_q) begin
            tmr_d      = tim_q[TExt];
            ext_used_d = 1'b1;
          end else if (p_q == 2'd0 && nxt == 2'd0 && !walk_any) begin
            tmr_d = tim_q[TGreen];
          end else begin
            st_d  = StYellow;
            tmr_d = tim_q[TYel];
          end
        end
        StYellow: begin
          st_d  = StAllred;
          tmr_d = TIME_W'(1);
        end
        StAllred: begin
          if (walk_any) begin
            st_d        = StWalk;
            tmr_d       = tim_q[TWalk];
            served_d    = walk_pend_q;
            walk_pend_d = walk_req;
          end else begin
            st_d       = StGreen;
            p_d        = nxt;
            ext_used_d = 1'b0;
            tmr_d      = tim_q[TGreen];
          end
        end
        StWalk: begin
          st_d       = StGreen;
          p_d        = nxt;
          served_d   = '0;
          ext_used_d = 1'b0;
          tmr_d      = tim_q[TGreen];
        end
        default: begin
          st_d  = StGreen;
          p_d   = 2'd0;
          tmr_d = tim_q[TGreen];
        end
      endcase
    end
  end

  // Lamps are decoded from next state so they change on the same edge as the FSM.
  always_comb begin
    sel4     = 4'b0001 << p_d;
    green_d  = (st_d == StGreen)  ? sel4[N_PHASES-1:0] : '0;
    yellow_d = (st_d == StYellow) ? sel4[N_PHASES-1:0] : '0;
    red_d    = ~(green_d | yellow_d);
    walk_d   = (st_d == StWalk) ? served_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= StGreen;
      p_q         <= 2'd0;
      div_q       <= '0;
      tmr_q       <= TIME_W'(DEF_GREEN);
      ext_used_q  <= 1'b0;
      walk_pend_q <= '0;
      served_q    <= '0;
      tim_q[0]    <= TIME_W'(DEF_GREEN);
      tim_q[1]    <= TIME_W'(DEF_EXT);
      tim_q[2]    <= TIME_W'(DEF_YEL);
      tim_q[3]    <= TIME_W'(DEF_WALK);
      green_q     <= N_PHASES'(1);
      red_q       <= ~N_PHASES'(1);
      yellow_q    <= '0;
      walk_q      <= '0;
    end else begin
      st_q        <= st_d;
      p_q         <= p_d;
      div_q       <= div_d;
      tmr_q       <= tmr_d;
      ext_used_q  <= ext_used_d;
      walk_pend_q <= walk_pend_d;
      served_q    <= served_d;
      tim_q       <= tim_d;
      green_q     <= green_d;
      red_q       <= red_d;
      yellow_q    <= yellow_d;
      walk_q      <= walk_d;
    end
  end

  assign red    = red_q;
  assign yellow = yellow_q;
  assign green  = green_q;
  assign walk   = walk_q;
  assign phase  = p_q;

endmodule
